// File: rtl/serpent_subkey_fetch.sv
// Streams the 33 Serpent subkeys from the subkey memory to the round engine,
// ascending for encrypt and descending for decrypt, through a 2-entry prefetch buffer.
module serpent_subkey_fetch #(
    parameter int NUM_SUBKEYS = 33,
    parameter int ADDR_W      = 6,
    parameter int KEY_W       = 128
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic              i_start,
    input  logic              i_dir,
    input  logic              i_keys_ready,
    input  logic              i_abort,
    output logic              o_mem_read_en,
    output logic [ADDR_W-1:0] o_mem_addr,
    input  logic [KEY_W-1:0]  i_mem_key,
    output logic [KEY_W-1:0]  o_subkey,
    output logic              o_subkey_valid,
    input  logic              i_subkey_ready,
    output logic [ADDR_W-1:0] o_round_idx,
    output logic              o_last,
    output logic              o_busy,
    output logic              o_done
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_KEYS = 2'd1,
        ST_FETCH     = 2'd2,
        ST_DONE      = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_SUBKEYS - 1);
    localparam logic [ADDR_W-1:0] NUM_C    = ADDR_W'(NUM_SUBKEYS);

    state_t             state_r;
    state_t             state_s;
    logic               dir_r;
    logic [ADDR_W-1:0]  rd_ptr_r;
    logic [ADDR_W-1:0]  issued_r;
    logic [ADDR_W-1:0]  accepted_r;
    logic               inflight_r;
    logic [1:0]         occ_r;
    logic [KEY_W-1:0]   buf0_r;
    logic [KEY_W-1:0]   buf1_r;

    logic               valid_s;
    logic               pop_s;
    logic               issue_s;
    logic               start_s;
    logic               flush_s;
    logic               last_hs_s;
    logic [2:0]         fill_s;

    // Handshake, issue and flush decisions
    always_comb begin
        valid_s   = (occ_r != 2'd0);
        pop_s     = valid_s & i_subkey_ready;
        fill_s    = {1'b0, occ_r} + {2'b00, inflight_r};
        flush_s   = i_abort && (state_r != ST_IDLE);
        start_s   = (state_r == ST_IDLE) && i_start && !i_abort;
        last_hs_s = pop_s && (accepted_r == LAST_IDX);
        // Buffer slots still free once this cycle's pop is taken into account
        issue_s   = (state_r == ST_FETCH) && !i_abort && (issued_r < NUM_C)
                    && (fill_s < (3'd2 + {2'b00, pop_s}));
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        if (flush_s) begin
            state_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start_s) begin
                        state_s = i_keys_ready ? ST_FETCH : ST_WAIT_KEYS;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_WAIT_KEYS: begin
                    if (i_keys_ready) begin
                        state_s = ST_FETCH;
                    end else begin
                        state_s = ST_WAIT_KEYS;
                    end
                end
                ST_FETCH: begin
                    if (last_hs_s) begin
                        state_s = ST_DONE;
                    end else begin
                        state_s = ST_FETCH;
                    end
                end
                ST_DONE:  state_s = ST_IDLE;
                default:  state_s = ST_IDLE;
            endcase
        end
    end

    // State register
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Direction latch, read pointer and issue/accept counters
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            dir_r      <= 1'b0;
            rd_ptr_r   <= {ADDR_W{1'b0}};
            issued_r   <= {ADDR_W{1'b0}};
            accepted_r <= {ADDR_W{1'b0}};
            inflight_r <= 1'b0;
        end else if (flush_s) begin
            rd_ptr_r   <= {ADDR_W{1'b0}};
            issued_r   <= {ADDR_W{1'b0}};
            accepted_r <= {ADDR_W{1'b0}};
            inflight_r <= 1'b0;
        end else if (start_s) begin
            dir_r      <= i_dir;
            rd_ptr_r   <= i_dir ? {ADDR_W{1'b0}} : LAST_IDX;
            issued_r   <= {ADDR_W{1'b0}};
            accepted_r <= {ADDR_W{1'b0}};
            inflight_r <= 1'b0;
        end else begin
            inflight_r <= issue_s;
            if (issue_s) begin
                issued_r <= issued_r + {{(ADDR_W-1){1'b0}}, 1'b1};
                // The pointer stays on the final address so it never leaves the key range
                if (issued_r != LAST_IDX) begin
                    rd_ptr_r <= dir_r ? rd_ptr_r + {{(ADDR_W-1){1'b0}}, 1'b1}
                                      : rd_ptr_r - {{(ADDR_W-1){1'b0}}, 1'b1};
                end
            end
            if (pop_s) begin
                accepted_r <= accepted_r + {{(ADDR_W-1){1'b0}}, 1'b1};
            end
        end
    end

    // Two-entry FIFO; buf0_r is the head presented to the round engine
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            occ_r  <= 2'd0;
            buf0_r <= {KEY_W{1'b0}};
            buf1_r <= {KEY_W{1'b0}};
        end else if (flush_s) begin
            occ_r  <= 2'd0;
            buf0_r <= {KEY_W{1'b0}};
            buf1_r <= {KEY_W{1'b0}};
        end else begin
            case ({inflight_r, pop_s})
                2'b10: begin
                    if (occ_r == 2'd0) begin
                        buf0_r <= i_mem_key;
                    end else begin
                        buf1_r <= i_mem_key;
                    end
                    occ_r <= occ_r + 2'd1;
                end
                2'b01: begin
                    buf0_r <= buf1_r;
                    occ_r  <= occ_r - 2'd1;
                end
                2'b11: begin
                    if (occ_r == 2'd1) begin
                        buf0_r <= i_mem_key;
                    end else begin
                        buf0_r <= buf1_r;
                        buf1_r <= i_mem_key;
                    end
                end
                default: begin
                    occ_r <= occ_r;
                end
            endcase
        end
    end

    assign o_mem_read_en  = issue_s;
    assign o_mem_addr     = issue_s ? rd_ptr_r : {ADDR_W{1'b0}};
    assign o_subkey       = buf0_r;
    assign o_subkey_valid = valid_s;
    assign o_round_idx    = valid_s ? (dir_r ? accepted_r : LAST_IDX - accepted_r)
                                    : {ADDR_W{1'b0}};
    assign o_last         = valid_s && (accepted_r == LAST_IDX);
    assign o_busy         = (state_r != ST_IDLE);
    assign o_done         = (state_r == ST_DONE);

endmodule

// File: tb/tb_serpent_subkey_fetch.sv
// Directed bench for serpent_subkey_fetch: a behavioural 1-cycle-latency subkey
// memory holding key[n] = 128'hA5 ^ n, with hand-derived index, data and latency expectations.
module tb_serpent_subkey_fetch;

    localparam int N  = 33;
    localparam int AW = 6;
    localparam int KW = 128;

    logic          clk = 1'b0;
    logic          i_rstn;
    logic          i_start;
    logic          i_dir;
    logic          i_keys_ready;
    logic          i_abort;
    logic          o_mem_read_en;
    logic [AW-1:0] o_mem_addr;
    logic [KW-1:0] i_mem_key;
    logic [KW-1:0] o_subkey;
    logic          o_subkey_valid;
    logic          i_subkey_ready;
    logic [AW-1:0] o_round_idx;
    logic          o_last;
    logic          o_busy;
    logic          o_done;

    logic [KW-1:0] mem [0:N-1];
    logic [KW-1:0] mem_q = {KW{1'b0}};

    int n_cmp = 0;
    int n_err = 0;
    int fv, lh, dc, acc;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (o_mem_read_en) mem_q <= mem[o_mem_addr];
    end
    assign i_mem_key = mem_q;

    serpent_subkey_fetch #(.NUM_SUBKEYS(N), .ADDR_W(AW), .KEY_W(KW)) dut (
        .i_clk          (clk),
        .i_rstn         (i_rstn),
        .i_start        (i_start),
        .i_dir          (i_dir),
        .i_keys_ready   (i_keys_ready),
        .i_abort        (i_abort),
        .o_mem_read_en  (o_mem_read_en),
        .o_mem_addr     (o_mem_addr),
        .i_mem_key      (i_mem_key),
        .o_subkey       (o_subkey),
        .o_subkey_valid (o_subkey_valid),
        .i_subkey_ready (i_subkey_ready),
        .o_round_idx    (o_round_idx),
        .o_last         (o_last),
        .o_busy         (o_busy),
        .o_done         (o_done)
    );

    function automatic logic [KW-1:0] key_of(input int n);
        key_of = 128'hA5 ^ KW'(n);
    endfunction

    task automatic check_eq(input string tag, input logic [KW-1:0] obs, input logic [KW-1:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_rd_en"}, o_mem_read_en, 1'b0);
        check_eq({tag, "_addr"},  o_mem_addr, 6'd0);
        check_eq({tag, "_key"},   o_subkey, 128'd0);
        check_eq({tag, "_valid"}, o_subkey_valid, 1'b0);
        check_eq({tag, "_idx"},   o_round_idx, 6'd0);
        check_eq({tag, "_last"},  o_last, 1'b0);
        check_eq({tag, "_busy"},  o_busy, 1'b0);
        check_eq({tag, "_done"},  o_done, 1'b0);
    endtask

    // One run; cyc counts cycles after the edge that moves the block into FETCH.
    task automatic stream(input logic dir, input int mode, input int wait_cyc, input int abort_at,
                          output int first_v, output int last_hs, output int done_c, output int n_acc);
        int          rd_cnt;
        int          exp_idx;
        int          pop_i;
        logic        stalled;
        logic [KW-1:0] held_key;
        first_v = -1; last_hs = -1; done_c = -1; n_acc = 0;
        rd_cnt = 0; stalled = 1'b0; held_key = {KW{1'b0}};
        @(negedge clk);
        i_start = 1'b1; i_dir = dir; i_keys_ready = (wait_cyc == 0);
        for (int w = 1; w <= wait_cyc; w++) begin
            @(negedge clk);
            i_start = 1'b0;
            #1;
            check_eq("wait_busy", o_busy, 1'b1);
            check_eq("wait_noread", o_mem_read_en, 1'b0);
            if (w == wait_cyc) i_keys_ready = 1'b1;
        end
        for (int cyc = 1; cyc <= 300; cyc++) begin
            @(negedge clk);
            i_start        = (cyc >= 5 && cyc <= 10);
            i_dir          = (cyc >= 5) ? ~dir : dir;
            if (cyc >= 8) i_keys_ready = 1'b0;
            i_subkey_ready = (mode == 0) ? 1'b1 : ((cyc % 4) == 0 || (cyc % 4) == 3);
            #1;
            if (cyc == 1) check_eq("first_read", o_mem_read_en, 1'b1);
            pop_i = (o_subkey_valid && i_subkey_ready) ? 1 : 0;
            if (o_mem_read_en) begin
                check_eq("rd_limit", rd_cnt < N, 1'b1);
                check_eq("rd_addr", o_mem_addr, dir ? rd_cnt : N - 1 - rd_cnt);
                check_eq("rd_occ", (rd_cnt - n_acc - pop_i) < 2, 1'b1);
                rd_cnt++;
            end
            if (stalled) begin
                check_eq("hold_valid", o_subkey_valid, 1'b1);
                check_eq("stable", o_subkey, held_key);
            end
            if (o_subkey_valid) begin
                if (first_v < 0) first_v = cyc;
                exp_idx = dir ? n_acc : N - 1 - n_acc;
                check_eq("idx", o_round_idx, exp_idx);
                check_eq("key", o_subkey, key_of(exp_idx));
                check_eq("last", o_last, n_acc == N - 1);
                stalled  = !i_subkey_ready;
                held_key = o_subkey;
                if (i_subkey_ready) begin
                    n_acc++;
                    last_hs = cyc;
                end
            end else begin
                stalled = 1'b0;
            end
            if (o_done) begin
                done_c = cyc;
                check_eq("done_acc", n_acc, N);
                break;
            end
            if (abort_at > 0 && n_acc == abort_at) break;
        end
        i_start = 1'b0;
        if (abort_at == 0) check_eq("done_seen", done_c > 0, 1'b1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        i_rstn = 1'b0; i_start = 1'b0; i_dir = 1'b0; i_keys_ready = 1'b0;
        i_abort = 1'b0; i_subkey_ready = 1'b0;
        for (int n = 0; n < N; n++) mem[n] = key_of(n);

        repeat (2) @(negedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        i_rstn = 1'b1;

        // Encrypt, ready held high: exact latency
        stream(1'b1, 0, 0, 0, fv, lh, dc, acc);
        check_eq("enc_first_valid", fv, 3);
        check_eq("enc_last_hs", lh, 35);
        check_eq("enc_done_cyc", dc, 36);
        @(negedge clk);
        i_subkey_ready = 1'b0;
        #1;
        check_eq("enc_idle", o_busy, 1'b0);
        check_eq("enc_done_pulse", o_done, 1'b0);

        // Decrypt, ready held high
        stream(1'b0, 0, 0, 0, fv, lh, dc, acc);
        check_eq("dec_first_valid", fv, 3);
        check_eq("dec_done_cyc", dc, 36);

        // Backpressure in both directions
        stream(1'b1, 1, 0, 0, fv, lh, dc, acc);
        check_eq("bp_enc_acc", acc, N);
        stream(1'b0, 1, 0, 0, fv, lh, dc, acc);
        check_eq("bp_dec_acc", acc, N);

        // Start before keys are ready
        stream(1'b1, 0, 5, 0, fv, lh, dc, acc);
        check_eq("wk_first_valid", fv, 3);
        check_eq("wk_done_cyc", dc, 36);

        // Abort after 10 accepted subkeys with a read in flight
        stream(1'b1, 0, 0, 10, fv, lh, dc, acc);
        @(negedge clk);
        i_abort = 1'b1; i_subkey_ready = 1'b0;
        #1;
        check_eq("abort_busy_pre", o_busy, 1'b1);
        @(negedge clk);
        i_abort = 1'b0;
        #1;
        check_eq("abort_idle", o_busy, 1'b0);
        check_eq("abort_valid", o_subkey_valid, 1'b0);
        check_eq("abort_done", o_done, 1'b0);
        repeat (3) begin
            @(negedge clk);
            #1;
            check_eq("abort_quiet_valid", o_subkey_valid, 1'b0);
            check_eq("abort_quiet_done", o_done, 1'b0);
        end
        stream(1'b1, 0, 0, 0, fv, lh, dc, acc);
        check_eq("restart_first_valid", fv, 3);
        check_eq("restart_done_cyc", dc, 36);

        // Asynchronous reset in the middle of FETCH
        stream(1'b0, 1, 0, 8, fv, lh, dc, acc);
        #2;
        i_rstn = 1'b0;
        #1;
        check_all_zero("async_rst");
        i_start = 1'b1; i_keys_ready = 1'b1; i_dir = 1'b1;
        repeat (3) begin
            @(negedge clk);
            #1;
            check_eq("rst_held_busy", o_busy, 1'b0);
            check_eq("rst_held_read", o_mem_read_en, 1'b0);
        end
        @(negedge clk);
        i_start = 1'b0;
        i_rstn  = 1'b1;
        stream(1'b0, 0, 0, 0, fv, lh, dc, acc);
        check_eq("post_rst_done_cyc", dc, 36);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
